counter_32_ctrl: RTL and testbench

Sequencer that drives a `counter_32_rev` instance as a programmable period timer: it computes and loads the preload value, holds the count direction, watches the counter's `RC` ripple-carry, reloads on every terminal count and emits one `tick` per period for a requested number of periods. It sits between the register/control layer (start, period, repeat count) and the counter's `s` / `Load` / `PData` / `cnt` / `RC` port group, so the counter's interface is now driven by a block instead of a bench.

---
 rtl/counter_32_ctrl_if.sv | 41 ++++
 rtl/counter_32_ctrl.sv | 136 +++++++++++++
 tb/tb_counter_32_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_32_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_32_ctrl_if
//   Signal bundle between the period-timer sequencer and its surroundings
//   (register/control layer plus the counter_32_rev port group).
//
//   Control layer -> sequencer : start, stop, dir, period[31:0], reps[7:0]
//   Counter       -> sequencer : RC (ripple-carry), cnt[31:0] (debug only)
//   Sequencer     -> counter   : s (direction), Load, PData[31:0]
//   Sequencer     -> status    : busy, tick, done, err, rep_cnt[7:0]
//
//   master : the sequencer side (counter_32_ctrl)
//   slave  : the environment side (control layer + counter)
// ---------------------------------------------------------------------------
interface counter_32_ctrl_if;
    logic        start;
    logic        stop;
    logic        dir;
    logic [31:0] period;
    logic [7:0]  reps;
    logic        RC;
    logic [31:0] cnt;

    logic        s;
    logic        Load;
    logic [31:0] PData;
    logic        busy;
    logic        tick;
    logic        done;
    logic        err;
    logic [7:0]  rep_cnt;

    modport master (
        input  start, stop, dir, period, reps, RC, cnt,
        output s, Load, PData, busy, tick, done, err, rep_cnt
    );

    modport slave (
        output start, stop, dir, period, reps, RC, cnt,
        input  s, Load, PData, busy, tick, done, err, rep_cnt
    );
endinterface

// File: rtl/counter_32_ctrl.sv
// ---------------------------------------------------------------------------
// counter_32_ctrl
//   Programmable period timer sequencer driving a counter_32_rev instance.
//   On start it latches direction and repeat count, computes the preload so
//   the counter reaches its terminal count (RC) after exactly P cycles, loads
//   it, then reloads on every RC with zero gap, emitting one tick per period
//   until the requested number of periods has elapsed (or forever if reps=0).
//
//   Ports:
//     clk   : rising-edge clock, shared with the counter
//     rst_n : asynchronous active-low reset
//     bus   : counter_32_ctrl_if.master (see interface header for members)
// ---------------------------------------------------------------------------
module counter_32_ctrl (
    input  logic                      clk,
    input  logic                      rst_n,
    counter_32_ctrl_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [31:0] pdata_q, pdata_d;
    logic [7:0]  reps_q, reps_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        load;

    logic        start_ok;
    logic        last_rep;
    logic [31:0] p_minus_1;

    assign start_ok  = bus.start && (bus.period != 32'd0);
    // reps_q = 0 means free-run, so it can never be the final rep.
    assign last_rep  = (reps_q != 8'd0) && ((rep_cnt_q + 8'd1) == reps_q);
    assign p_minus_1 = bus.period - 32'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: state_d = bus.stop ? IDLE : RUN;
            RUN: begin
                if (bus.stop)                state_d = IDLE;
                else if (bus.RC && last_rep) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        s_d       = s_q;
        pdata_d   = pdata_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    s_d       = bus.dir;
                    reps_d    = bus.reps;
                    // Up-count terminates at FFFFFFFF, down-count at 0; both
                    // preloads put RC exactly P-1 counts away from the load.
                    pdata_d   = bus.dir ? ~p_minus_1 : p_minus_1;
                    rep_cnt_d = 8'd0;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end
            end
            LOAD: load = 1'b1;
            RUN: begin
                // stop overrides RC: no tick and no reload on a coincident edge.
                if (!bus.stop && bus.RC) begin
                    tick_d    = 1'b1;
                    rep_cnt_d = rep_cnt_q + 8'd1;
                    if (last_rep) done_d = 1'b1;
                    else          load   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            pdata_q   <= 32'd0;
            reps_q    <= 8'd0;
            rep_cnt_q <= 8'd0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s_q       <= s_d;
            pdata_q   <= pdata_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.s       = s_q;
    assign bus.PData   = pdata_q;
    assign bus.Load    = load;
    assign bus.busy    = (state_q == LOAD) || (state_q == RUN);
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_counter_32_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_counter_32_ctrl
//   Directed bench for counter_32_ctrl with a behavioural counter_32_rev
//   model closing the RC loop.
// ---------------------------------------------------------------------------
module tb_counter_32_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    counter_32_ctrl_if bus ();

    counter_32_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter_32_rev: synchronous load, up/down, combinational RC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        bus.cnt <= 32'd0;
        else if (bus.Load) bus.cnt <= bus.PData;
        else if (bus.s)    bus.cnt <= bus.cnt + 32'd1;
        else               bus.cnt <= bus.cnt - 32'd1;
    end
    assign bus.RC = bus.s ? (bus.cnt == 32'hFFFF_FFFF) : (bus.cnt == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_s"},       {31'd0, bus.s},    32'd0);
        chk({pfx, "_PData"},   bus.PData,         32'd0);
        chk({pfx, "_Load"},    {31'd0, bus.Load}, 32'd0);
        chk({pfx, "_busy"},    {31'd0, bus.busy}, 32'd0);
        chk({pfx, "_tick"},    {31'd0, bus.tick}, 32'd0);
        chk({pfx, "_done"},    {31'd0, bus.done}, 32'd0);
        chk({pfx, "_err"},     {31'd0, bus.err},  32'd0);
        chk({pfx, "_rep_cnt"}, {24'd0, bus.rep_cnt}, 32'd0);
    endtask

    // Up, P=3, reps=2; returns at T+8 (IDLE again).
    task automatic run_up3x2(input string pfx);
        bus.dir = 1'b1; bus.period = 32'd3; bus.reps = 8'd2; bus.start = 1'b1;
        step();                                            // edge T
        bus.start = 1'b0;
        chk({pfx, "_T0_Load"},  {31'd0, bus.Load}, 32'd1);
        chk({pfx, "_T0_busy"},  {31'd0, bus.busy}, 32'd1);
        chk({pfx, "_T0_s"},     {31'd0, bus.s},    32'd1);
        chk({pfx, "_T0_PData"}, bus.PData,         32'hFFFF_FFFD);
        step();                                            // T+1
        chk({pfx, "_T1_cnt"},   bus.cnt,           32'hFFFF_FFFD);
        chk({pfx, "_T1_Load"},  {31'd0, bus.Load}, 32'd0);
        step(); step();                                    // T+3
        chk({pfx, "_T3_cnt"},   bus.cnt,           32'hFFFF_FFFF);
        chk({pfx, "_T3_Load"},  {31'd0, bus.Load}, 32'd1);
        step();                                            // T+4
        chk({pfx, "_T4_tick"},  {31'd0, bus.tick}, 32'd1);
        chk({pfx, "_T4_rep"},   {24'd0, bus.rep_cnt}, 32'd1);
        chk({pfx, "_T4_cnt"},   bus.cnt,           32'hFFFF_FFFD);
        chk({pfx, "_T4_done"},  {31'd0, bus.done}, 32'd0);
        step();                                            // T+5
        chk({pfx, "_T5_tick"},  {31'd0, bus.tick}, 32'd0);
        step();                                            // T+6
        chk({pfx, "_T6_cnt"},   bus.cnt,           32'hFFFF_FFFF);
        chk({pfx, "_T6_Load"},  {31'd0, bus.Load}, 32'd0);
        step();                                            // T+7
        chk({pfx, "_T7_tick"},  {31'd0, bus.tick}, 32'd1);
        chk({pfx, "_T7_done"},  {31'd0, bus.done}, 32'd1);
        chk({pfx, "_T7_rep"},   {24'd0, bus.rep_cnt}, 32'd2);
        chk({pfx, "_T7_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({pfx, "_T7_cnt"},   bus.cnt,           32'd0);
        step();                                            // T+8
        chk({pfx, "_T8_done"},  {31'd0, bus.done}, 32'd0);
        chk({pfx, "_T8_tick"},  {31'd0, bus.tick}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.dir    = 1'b0;
        bus.period = 32'd0;
        bus.reps   = 8'd0;

        // Reset state
        #12;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // Up, P=3, reps=2
        run_up3x2("up");

        // Down, P=3, reps=1
        bus.dir = 1'b0; bus.period = 32'd3; bus.reps = 8'd1; bus.start = 1'b1;
        step();                                            // T
        bus.start = 1'b0;
        chk("dn_T0_PData", bus.PData,          32'd2);
        chk("dn_T0_s",     {31'd0, bus.s},     32'd0);
        step(); step(); step();                            // T+3
        chk("dn_T3_cnt",   bus.cnt,            32'd0);
        chk("dn_T3_Load",  {31'd0, bus.Load},  32'd0);
        step();                                            // T+4
        chk("dn_T4_tick",  {31'd0, bus.tick},  32'd1);
        chk("dn_T4_done",  {31'd0, bus.done},  32'd1);
        chk("dn_T4_rep",   {24'd0, bus.rep_cnt}, 32'd1);
        chk("dn_T4_cnt",   bus.cnt,            32'hFFFF_FFFF);
        step();                                            // T+5
        chk("dn_T5_done",  {31'd0, bus.done},  32'd0);
        chk("dn_T5_cnt",   bus.cnt,            32'hFFFF_FFFE);

        // P=1, free-run, stop after 10 ticks
        bus.dir = 1'b0; bus.period = 32'd1; bus.reps = 8'd0; bus.start = 1'b1;
        step();                                            // T
        bus.start = 1'b0;
        chk("p1_T0_PData", bus.PData,          32'd0);
        step();                                            // T+1
        chk("p1_T1_Load",  {31'd0, bus.Load},  32'd1);
        for (int k = 2; k <= 11; k++) begin
            step();
            chk($sformatf("p1_T%0d_tick", k), {31'd0, bus.tick}, 32'd1);
            chk($sformatf("p1_T%0d_rep", k),  {24'd0, bus.rep_cnt}, k - 1);
            chk($sformatf("p1_T%0d_Load", k), {31'd0, bus.Load}, 32'd1);
        end
        bus.stop = 1'b1;
        #1;
        chk("p1_stop_Load", {31'd0, bus.Load}, 32'd0);
        step();
        bus.stop = 1'b0;
        chk("p1_stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("p1_stop_tick", {31'd0, bus.tick}, 32'd0);
        chk("p1_stop_done", {31'd0, bus.done}, 32'd0);
        chk("p1_stop_rep",  {24'd0, bus.rep_cnt}, 32'd10);

        // period = 0 rejected
        bus.period = 32'd0; bus.start = 1'b1;
        #1;
        chk("p0_Load_pre", {31'd0, bus.Load}, 32'd0);
        step();
        bus.start = 1'b0;
        chk("p0_err",  {31'd0, bus.err},  32'd1);
        chk("p0_busy", {31'd0, bus.busy}, 32'd0);
        chk("p0_Load", {31'd0, bus.Load}, 32'd0);
        step();
        chk("p0_err_clr", {31'd0, bus.err},  32'd0);
        chk("p0_busy2",   {31'd0, bus.busy}, 32'd0);

        // stop on the RC edge of rep 1 of 3
        bus.dir = 1'b1; bus.period = 32'd3; bus.reps = 8'd3; bus.start = 1'b1;
        step();                                            // T
        bus.start = 1'b0;
        step(); step(); step();                            // T+3
        chk("sr_T3_RC", {31'd0, bus.RC}, 32'd1);
        bus.stop = 1'b1;
        #1;
        chk("sr_Load", {31'd0, bus.Load}, 32'd0);
        step();                                            // T+4
        bus.stop = 1'b0;
        chk("sr_tick", {31'd0, bus.tick}, 32'd0);
        chk("sr_rep",  {24'd0, bus.rep_cnt}, 32'd0);
        chk("sr_busy", {31'd0, bus.busy}, 32'd0);
        chk("sr_done", {31'd0, bus.done}, 32'd0);

        // Asynchronous reset mid-run, then a clean re-run
        bus.dir = 1'b1; bus.period = 32'd3; bus.reps = 8'd2; bus.start = 1'b1;
        step();                                            // T
        bus.start = 1'b0;
        step(); step(); step();                            // T+3
        chk("ar_T3_Load", {31'd0, bus.Load}, 32'd1);
        step();                                            // T+4
        chk("ar_T4_tick", {31'd0, bus.tick}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        #2;
        rst_n = 1'b1;
        step();
        run_up3x2("rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
